// File: rtl/arity_truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps every N_IN-bit vector into a combinational DUT,
// holds each for SETTLE cycles, and compares the DUT response against the GOLDEN table.
module arity_truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0] GOLDEN = 24'o00007654
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1'b1);
    localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1'b1);
    localparam logic [3:0]      CNT_ZERO = 4'd0;
    localparam logic [3:0]      CNT_ONE  = 4'd1;
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

    // Expected DUT response for one input vector, taken from the packed GOLDEN table.
    function automatic logic [N_OUT-1:0] golden_at(input logic [N_IN-1:0] vec);
        golden_at = GOLDEN[int'(vec)*N_OUT +: N_OUT];
    endfunction

    state_t            r_state;
    logic [N_IN-1:0]   r_dut_in;
    logic [3:0]        r_hold_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_err_count;
    logic              r_ff_valid;
    logic [N_IN-1:0]   r_ff_vec;

    state_t            w_state_nxt;
    logic [N_IN-1:0]   w_dut_in_nxt;
    logic [3:0]        w_hold_cnt_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic [N_IN:0]     w_err_count_nxt;
    logic              w_ff_valid_nxt;
    logic [N_IN-1:0]   w_ff_vec_nxt;
    logic              w_mismatch;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_dut_in_nxt    = r_dut_in;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_err_count_nxt = r_err_count;
        w_ff_valid_nxt  = r_ff_valid;
        w_ff_vec_nxt    = r_ff_vec;
        w_mismatch      = (dut_out != golden_at(r_dut_in));

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    // Abort wins over start; the last sweep's statistics stay visible.
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end else if (start) begin
                    w_state_nxt     = ST_HOLD;
                    w_dut_in_nxt    = VEC_ZERO;
                    w_hold_cnt_nxt  = CNT_ZERO;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_err_count_nxt = ERR_ZERO;
                    w_ff_valid_nxt  = 1'b0;
                    w_ff_vec_nxt    = VEC_ZERO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_dut_in_nxt   = VEC_ZERO;
                    w_hold_cnt_nxt = CNT_ZERO;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                end else if (r_hold_cnt == CNT_LAST) begin
                    w_hold_cnt_nxt = CNT_ZERO;
                    if (w_mismatch) begin
                        w_err_count_nxt = r_err_count + ERR_ONE;
                        if (!r_ff_valid) begin
                            w_ff_valid_nxt = 1'b1;
                            w_ff_vec_nxt   = r_dut_in;
                        end else begin
                            w_ff_valid_nxt = r_ff_valid;
                        end
                    end else begin
                        w_err_count_nxt = r_err_count;
                    end
                    if (r_dut_in == VEC_LAST) begin
                        // Pass must account for the compare happening on this same edge.
                        w_state_nxt  = ST_DONE;
                        w_dut_in_nxt = VEC_ZERO;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_pass_nxt   = (r_err_count == ERR_ZERO) && !w_mismatch;
                    end else begin
                        w_dut_in_nxt = r_dut_in + VEC_ONE;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_dut_in_nxt    = VEC_ZERO;
                w_hold_cnt_nxt  = CNT_ZERO;
                w_busy_nxt      = 1'b0;
                w_done_nxt      = 1'b0;
                w_pass_nxt      = 1'b0;
                w_err_count_nxt = ERR_ZERO;
                w_ff_valid_nxt  = 1'b0;
                w_ff_vec_nxt    = VEC_ZERO;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dut_in    <= VEC_ZERO;
            r_hold_cnt  <= CNT_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= ERR_ZERO;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= VEC_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_dut_in    <= w_dut_in_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            r_ff_valid  <= w_ff_valid_nxt;
            r_ff_vec    <= w_ff_vec_nxt;
        end
    end

    assign dut_in           = r_dut_in;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;

endmodule

// File: doc/arity_truth_table_sweeper.md
ARITY_TRUTH_TABLE_SWEEPER -- requirements
Module: arity_truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 3, meaning the DUT input width; exhaustive sweep of 2^N_IN vectors.
REQ-002 SHALL have parameter N_OUT, default 3, meaning the DUT output width.
REQ-003 SHALL have parameter SETTLE, default 2, meaning cycles each vector is held (legal range 1..15).
REQ-004 SHALL have parameter GOLDEN, width N_OUT*2^N_IN, default 24'o00007654, meaning the expected DUT output for vector v at bits [v*N_OUT +: N_OUT].
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: begin a sweep (level sampled per cycle).
REQ-008 SHALL have port abort, input, 1: terminate the sweep without result.
REQ-009 SHALL have port dut_in, output, N_IN: vector driven to the DUT's io_in, registered.
REQ-010 SHALL have port dut_out, input, N_OUT: the DUT's io_out (combinational DUT).
REQ-011 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-012 SHALL have port done, output, 1: high from sweep completion until the next start, abort or reset.
REQ-013 SHALL have port pass, output, 1: high with done when err_count is 0.
REQ-014 SHALL have port err_count, output, N_IN+1: number of mismatching vectors in the last sweep.
REQ-015 SHALL have port first_fail_valid, output, 1, and port first_fail_vec, output, N_IN: lowest mismatching vector.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE or DONE with start=1 and abort=0, go to HOLD next edge: dut_in=0, busy=1, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, hold counter=0.
REQ-018 SHALL hold each vector on dut_in for exactly SETTLE cycles; at the edge ending the SETTLE-th cycle compare dut_out with GOLDEN[dut_in*N_OUT +: N_OUT].
REQ-019 SHALL, on mismatch, increment err_count; if first_fail_valid=0, load first_fail_vec=dut_in and set first_fail_valid=1 on the same edge.
REQ-020 SHALL, after compare, increment dut_in by 1 if dut_in < 2^N_IN-1, else go to DONE (no wrap; dut_in returns to 0).
REQ-021 SHALL, entering DONE, set busy=0, done=1, pass=1 iff final err_count (including the last compare) is 0.
REQ-022 SHALL give sweep latency: busy high exactly 2^N_IN*SETTLE cycles; done rises the cycle after busy falls... concretely on the same edge busy falls.
REQ-023 SHALL ignore start while in HOLD.
REQ-024 SHALL, on abort=1 in HOLD, go to IDLE next edge: busy=0, done=0, pass=0, dut_in=0; err_count and first_fail_* keep values; abort in IDLE/DONE: DONE goes to IDLE, done/pass cleared.
REQ-025 SHALL give abort priority over start when both high in the same cycle.
REQ-026 SHALL not saturate err_count; N_IN+1 bits hold the maximum 2^N_IN.
REQ-027 SHALL drive every output from a register; no combinational path from dut_out, start or abort to any output.

Reset
REQ-028 SHALL, while rst_n=0 (including mid-sweep), immediately force IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, hold counter=0.
REQ-029 SHALL leave IDLE only on a start sampled at a clk edge after rst_n deasserts.

Verification
REQ-030 SHALL verify correct DUT model (v0..v7 -> 4,5,6,7,0,0,0,0), defaults, 1-cycle start -> busy 16 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
REQ-031 SHALL verify DUT output stuck at 0 -> err_count=4, first_fail_vec=0, first_fail_valid=1, pass=0.
REQ-032 SHALL verify DUT correct except vector 5 returns 4 -> err_count=1, first_fail_vec=5, pass=0.
REQ-033 SHALL verify start pulses at sweep cycles 3 and 10 -> no effect, busy still exactly 16 cycles; start+abort at cycle 6 -> IDLE next edge, done=0, dut_in=0.
REQ-034 SHALL verify rst_n low at sweep cycle 9, asynchronous to clk -> all outputs zero before next edge; new start -> full clean 16-cycle sweep with pass=1.
REQ-035 SHALL verify SETTLE=1 -> busy 8 cycles, dut_in stepping 0..7 every cycle, pass=1 on correct DUT.
